// File: rtl/memory_responder_if.sv
// MAR/MDR memory bus between the control unit (master) and the RAM responder (slave).
// Signal names match the original port list so the responder remains a drop-in replacement.
interface memory_responder_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic                  Read;
    logic                  Write;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] Data_In;
    logic [DATA_WIDTH-1:0] Data_Out;
    logic                  Mem_Ready;
    logic                  Busy;
    logic                  Err;

    modport master (
        output Read,
        output Write,
        output Address,
        output Data_In,
        input  Data_Out,
        input  Mem_Ready,
        input  Busy,
        input  Err
    );

    modport slave (
        input  Read,
        input  Write,
        input  Address,
        input  Data_In,
        output Data_Out,
        output Mem_Ready,
        output Busy,
        output Err
    );
endinterface

// File: rtl/memory_responder.sv
// Word-addressed RAM responder: edge-triggered Read/Write requests complete after
// WAIT_CYCLES extra cycles and are acknowledged by a one-cycle Mem_Ready pulse.
module memory_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input logic               Clock,
    input logic               Reset,
    memory_responder_if.slave bus
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  read_d;
    logic                  write_d;
    logic                  read_rise;
    logic                  write_rise;
    logic                  request;
    logic                  conflict;
    logic                  accept;
    logic                  reject;
    logic                  access;

    logic                  op_write;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // A rising strobe while both strobes are high is ambiguous and gets rejected.
    always_comb begin
        read_rise  = bus.Read & ~read_d;
        write_rise = bus.Write & ~write_d;
        request    = read_rise | write_rise;
        conflict   = request & bus.Read & bus.Write;
        accept     = (state == IDLE) & request & ~conflict;
        reject     = (state == IDLE) & conflict;
        access     = (state == WAIT) && (cnt == '0);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = WAIT;
            WAIT: if (cnt == '0) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            read_d   <= 1'b0;
            write_d  <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= '0;
            op_write <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            dout_q   <= '0;
        end else begin
            read_d  <= bus.Read;
            write_d <= bus.Write;
            err_q   <= reject;
            if (accept) begin
                cnt      <= CNT_WIDTH'(WAIT_CYCLES);
                op_write <= write_rise;
                addr_q   <= bus.Address;
                data_q   <= bus.Data_In;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access && !op_write) begin
                dout_q <= mem[addr_q];
            end
        end
    end

    // Array has no reset; Reset holds the FSM in IDLE so no write can land while asserted.
    always_ff @(posedge Clock) begin
        if (access && op_write) begin
            mem[addr_q] <= data_q;
        end
    end

    always_comb begin
        bus.Data_Out  = dout_q;
        bus.Mem_Ready = (state == RESP);
        bus.Busy      = (state == WAIT);
        bus.Err       = err_q;
    end
endmodule

// File: tb/tb_memory_responder.sv
// Randomised self-checking bench for memory_responder, driving a WAIT_CYCLES=2 and a
// WAIT_CYCLES=0 instance against an array-based reference with latency arithmetic.
module tb_memory_responder;
    localparam int AW = 9;
    localparam int DW = 32;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    logic          rd;
    logic          wr;
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;

    memory_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    memory_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    assign bus_a.Read    = rd & ~sel;
    assign bus_a.Write   = wr & ~sel;
    assign bus_a.Address = addr;
    assign bus_a.Data_In = wdata;
    assign bus_b.Read    = rd & sel;
    assign bus_b.Write   = wr & sel;
    assign bus_b.Address = addr;
    assign bus_b.Data_In = wdata;

    memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(2)) dut_a (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus_a)
    );

    memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) dut_b (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus_b)
    );

    logic          o_busy;
    logic          o_ready;
    logic          o_err;
    logic [DW-1:0] o_dout;
    assign o_busy  = sel ? bus_b.Busy      : bus_a.Busy;
    assign o_ready = sel ? bus_b.Mem_Ready : bus_a.Mem_Ready;
    assign o_err   = sel ? bus_b.Err       : bus_a.Err;
    assign o_dout  = sel ? bus_b.Data_Out  : bus_a.Data_Out;

    // Reference: per-instance memory image, validity flags and last read value.
    logic [DW-1:0] ref_mem [2][512];
    bit            known   [2][512];
    logic [DW-1:0] ref_dout[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (dut %0d, t=%0t): got %h expected %h", tag, sel, $time, got, exp);
        end
    endtask

    // One request: strobe high for 'hold' cycles, optionally disturbing the bus after acceptance.
    task automatic access(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold, input bit intrude);
        int            s;
        int            w;
        logic [DW-1:0] old_dout;
        logic [DW-1:0] new_dout;
        s        = sel ? 1 : 0;
        w        = sel ? 0 : 2;
        old_dout = ref_dout[s];
        addr     = a;
        wdata    = d;
        if (is_wr) begin
            wr          = 1'b1;
            new_dout    = old_dout;
            ref_mem[s][a] = d;
            known[s][a]   = 1'b1;
        end else begin
            rd       = 1'b1;
            new_dout = ref_mem[s][a];
        end
        for (int k = 1; k <= w + 4; k++) begin
            @(negedge Clock);
            check("busy", {31'b0, o_busy}, {31'b0, (k - 1 <= w)});
            check("mem_ready", {31'b0, o_ready}, {31'b0, (k == w + 2)});
            check("err_quiet", {31'b0, o_err}, 32'd0);
            check("data_out", o_dout, (k >= w + 2) ? new_dout : old_dout);
            if (k == 1) begin
                addr  = AW'($urandom);
                wdata = $urandom;
                if (intrude && hold > 1) begin
                    if (is_wr) rd = 1'b1;
                    else       wr = 1'b1;
                end
            end
            if (k >= hold) begin
                rd = 1'b0;
                wr = 1'b0;
            end
        end
        ref_dout[s] = new_dout;
        @(negedge Clock);
        check("idle_busy", {31'b0, o_busy}, 32'd0);
    endtask

    task automatic conflict(input logic [AW-1:0] a);
        addr  = a;
        wdata = $urandom;
        rd    = 1'b1;
        wr    = 1'b1;
        @(negedge Clock);
        check("err_both_rise", {31'b0, o_err}, 32'd1);
        check("busy_on_err", {31'b0, o_busy}, 32'd0);
        check("ready_on_err", {31'b0, o_ready}, 32'd0);
        @(negedge Clock);
        check("err_one_cycle", {31'b0, o_err}, 32'd0);
        rd = 1'b0;
        @(negedge Clock);
        check("err_drop", {31'b0, o_err}, 32'd0);
        rd = 1'b1;
        @(negedge Clock);
        check("err_rise_while_other_high", {31'b0, o_err}, 32'd1);
        check("busy_on_err2", {31'b0, o_busy}, 32'd0);
        rd = 1'b0;
        wr = 1'b0;
        @(negedge Clock);
        check("err_clear", {31'b0, o_err}, 32'd0);
        check("ready_after_err", {31'b0, o_ready}, 32'd0);
        @(negedge Clock);
    endtask

    task automatic reset_mid_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge Clock);
        check("busy_before_reset", {31'b0, o_busy}, 32'd1);
        wr = 1'b0;
        #2 Reset = 1'b1;
        #1;
        check("reset_async_busy", {31'b0, o_busy}, 32'd0);
        check("reset_async_ready", {31'b0, o_ready}, 32'd0);
        check("reset_async_err", {31'b0, o_err}, 32'd0);
        check("reset_async_dout", o_dout, 32'd0);
        repeat (2) @(negedge Clock);
        Reset       = 1'b0;
        ref_dout[0] = '0;
        ref_dout[1] = '0;
        @(negedge Clock);
        check("after_reset_busy", {31'b0, o_busy}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit            is_wr;
        int            s;
        int            hold;
        logic [AW-1:0] a;

        rd = 1'b0; wr = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
        ref_dout[0] = '0;
        ref_dout[1] = '0;
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1;
            check("reset_busy", {31'b0, o_busy}, 32'd0);
            check("reset_ready", {31'b0, o_ready}, 32'd0);
            check("reset_err", {31'b0, o_err}, 32'd0);
            check("reset_dout", o_dout, 32'd0);
        end
        sel = 1'b0;
        Reset = 1'b0;
        @(negedge Clock);

        access(1'b1, 9'h005, 32'hDEADBEEF, 1, 1'b0);
        access(1'b0, 9'h005, 32'h0, 4, 1'b0);
        access(1'b1, 9'h007, 32'h0BADF00D, 2, 1'b0);
        conflict(9'h007);
        access(1'b0, 9'h007, 32'h0, 1, 1'b0);
        access(1'b1, 9'h010, 32'hCAFEBABE, 1, 1'b0);
        reset_mid_write(9'h010, 32'h12345678);
        access(1'b0, 9'h010, 32'h0, 1, 1'b0);
        access(1'b0, 9'h005, 32'h0, 3, 1'b1);
        access(1'b1, 9'h010, 32'h13579BDF, 2, 1'b0);
        access(1'b0, 9'h010, 32'h0, 1, 1'b0);

        sel = 1'b1;
        @(negedge Clock);
        access(1'b1, 9'h1FF, 32'hA5A5A5A5, 1, 1'b0);
        access(1'b0, 9'h1FF, 32'h0, 1, 1'b0);

        repeat (80) begin
            sel = 1'($urandom_range(0, 1));
            s   = sel ? 1 : 0;
            @(negedge Clock);
            if ($urandom_range(0, 9) == 0) begin
                conflict(AW'($urandom));
            end else begin
                is_wr = 1'($urandom_range(0, 1));
                a     = AW'($urandom);
                if (!is_wr && !known[s][a]) a = sel ? 9'h1FF : 9'h005;
                hold = $urandom_range(1, (sel ? 0 : 2) + 4);
                access(is_wr, a, $urandom, hold, 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
